// File: rtl/ucisc_pkg.sv
// rtl/ucisc_pkg.sv - shared widths, fetch FSM states and queue entry type for the uCISC front end
package ucisc_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] word;
   } fetch_entry_t;

   // Sequential fetch address; wraps 16'hFFFF -> 16'h0000 by width truncation.
   function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
      return pc + 1'b1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, word} entries with flush and occupancy count
module fetch_queue
   import ucisc_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic               head_valid,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t      mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              empty;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // Flush wins over both push and pop; a push into a full queue is only
   // accepted when the head leaves in the same cycle.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   // Entry storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_valid = !empty;
   assign head       = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - uCISC fetch stage: PC, single-outstanding read FSM, prefetch queue; FETCH_BYPASS_EN adds zero-latency ack-to-decode path
module instruction_fetch
   import ucisc_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 16'h0000,
   parameter int                    QUEUE_DEPTH = 2
)(
   input  logic                  clock,
   input  logic                  reset_n,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   output logic [WORD_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0] instruction_pc,
   output logic                  instruction_valid,
   input  logic                  decode_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] fetch_pc;

   fetch_entry_t          push_data;
   fetch_entry_t          head;
   logic                  head_valid;
   logic [CNT_W-1:0]      q_count;
   logic                  q_push;
   logic                  q_pop;
   logic                  credit;
   logic                  ack_taken;
   logic                  bypass_take;

   // With no read in flight the only occupancy is what the queue already holds.
   assign credit = (q_count < CNT_W'(QUEUE_DEPTH));

   // A real (non-stale) read completing this cycle on the current path.
   assign ack_taken = (state == WAIT) && mem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
   assign bypass_take = ack_taken && (q_count == '0) && decode_ready;
`else
   assign bypass_take = 1'b0;
`endif

   assign push_data = '{pc: fetch_pc, word: mem_rdata};
   assign q_push    = ack_taken && !bypass_take;
   assign q_pop     = head_valid && decode_ready;

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (redirect),
      .push       (q_push),
      .push_data  (push_data),
      .pop        (q_pop),
      .head       (head),
      .head_valid (head_valid),
      .count      (q_count)
   );

`ifdef FETCH_BYPASS_EN
   // Decoder sees the queue head, or the memory word directly when the queue is empty.
   always_comb begin
      instruction       = head.word;
      instruction_pc    = head.pc;
      instruction_valid = head_valid;
      if (bypass_take) begin
         instruction       = mem_rdata;
         instruction_pc    = mem_addr;
         instruction_valid = 1'b1;
      end
   end
`else
   assign instruction       = head.word;
   assign instruction_pc    = head.pc;
   assign instruction_valid = head_valid;
`endif

   // Fetch FSM: issues one read at a time, tracks fetch_pc, and absorbs stale reads after redirects.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         mem_read <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  // Queue is flushed this cycle, so the new path can start immediately.
                  fetch_pc <= redirect_pc;
                  mem_read <= 1'b1;
                  mem_addr <= redirect_pc;
                  state    <= WAIT;
               end else if (credit) begin
                  mem_read <= 1'b1;
                  mem_addr <= fetch_pc;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
                  if (mem_ack) begin
                     mem_read <= 1'b0;
                     state    <= FETCH;
                  end else begin
                     // Keep the old request on the bus until memory finishes it.
                     state <= DISCARD;
                  end
               end else if (mem_ack) begin
                  fetch_pc <= next_pc(fetch_pc);
                  mem_read <= 1'b0;
                  state    <= FETCH;
               end
            end
            DISCARD: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
               end
               if (mem_ack) begin
                  mem_read <= 1'b0;
                  state    <= FETCH;
               end
            end
            default: begin
               mem_read <= 1'b0;
               state    <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_read;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instruction;
   logic [15:0] instruction_pc;
   logic        instruction_valid;
   logic        decode_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          ack_count = 0;
   logic [31:0] cons [$];

   always #5 clock = ~clock;

   instruction_fetch #(
      .RESET_PC    (16'h0010),
      .QUEUE_DEPTH (2)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .mem_read          (mem_read),
      .mem_addr          (mem_addr),
      .mem_ack           (mem_ack),
      .mem_rdata         (mem_rdata),
      .instruction       (instruction),
      .instruction_pc    (instruction_pc),
      .instruction_valid (instruction_valid),
      .decode_ready      (decode_ready),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] got(input int i);
      return (i < cons.size()) ? cons[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic pulse_redirect(input logic [15:0] pc);
      @(negedge clock); #2;
      redirect    = 1'b1;
      redirect_pc = pc;
      @(negedge clock); #2;
      redirect = 1'b0;
      cons.delete();
   endtask

   // Memory model: word = addr ^ 16'hA5A5, ack ack_delay cycles after the request is seen.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clock); #1;
         mem_ack = 1'b0;
         if (reset_n && mem_read) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_addr ^ 16'hA5A5;
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Record consumed instructions and count new-path acks in the 0x01xx window.
   initial begin
      forever begin
         @(negedge clock); #3;
         if (reset_n && instruction_valid && decode_ready && !redirect)
            cons.push_back({instruction_pc, instruction});
         if (reset_n && mem_read && mem_ack && mem_addr[15:8] == 8'h01)
            ack_count++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      int   n5;
      reset_n      = 1'b0;
      decode_ready = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = 16'h0000;

      // Reset state
      repeat (3) @(negedge clock); #2;
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_instr", instruction, 16'h0000);
      check("rst_instr_pc", instruction_pc, 16'h0000);
      check("rst_valid", instruction_valid, 1'b0);

      // First read in first cycle after release, then sequential stream
      reset_n = 1'b1;
      @(negedge clock); #2;
      check("first_read", mem_read, 1'b1);
      check("first_addr", mem_addr, 16'h0010);
      check("first_bypass_valid", instruction_valid, BYP);
      repeat (8) @(negedge clock); #2;
      check("seq_len", cons.size() >= 3, 1'b1);
      check("seq0", got(0), {16'h0010, 16'hA5B5});
      check("seq1", got(1), {16'h0011, 16'hA5B4});
      check("seq2", got(2), {16'h0012, 16'hA5B7});

      // Decoder stall: exactly two reads fill the queue, outputs hold
      decode_ready = 1'b0;
      ack_count    = 0;
      pulse_redirect(16'h0100);
      repeat (12) @(negedge clock); #2;
      check("stall_reads", ack_count, 2);
      check("stall_mem_read", mem_read, 1'b0);
      check("stall_valid", instruction_valid, 1'b1);
      check("stall_pc", instruction_pc, 16'h0100);
      check("stall_instr", instruction, 16'hA4A5);
      repeat (3) @(negedge clock); #2;
      check("stall_pc_hold", instruction_pc, 16'h0100);
      check("stall_instr_hold", instruction, 16'hA4A5);
      decode_ready = 1'b1;
      cons.delete();
      repeat (8) @(negedge clock); #2;
      check("drain0", got(0), {16'h0100, 16'hA4A5});
      check("drain1", got(1), {16'h0101, 16'hA4A4});
      check("drain2", got(2), {16'h0102, 16'hA4A7});

      // Redirect while read to 0x0005 outstanding, ack 3 cycles later
      ack_delay = 3;
      pulse_redirect(16'h0005);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock); #2;
         found = mem_read && (mem_addr == 16'h0005);
      end
      check("reach_0005", found, 1'b1);
      redirect    = 1'b1;
      redirect_pc = 16'h0200;
      @(negedge clock); #2;
      redirect = 1'b0;
      cons.delete();
      check("discard_read", mem_read, 1'b1);
      check("discard_addr", mem_addr, 16'h0005);
      check("discard_valid", instruction_valid, 1'b0);
      repeat (16) @(negedge clock); #2;
      n5 = 0;
      for (int i = 0; i < cons.size(); i++)
         if (cons[i][31:16] == 16'h0005) n5++;
      check("stale_absent", n5, 0);
      check("after_discard0", got(0), {16'h0200, 16'hA7A5});

      // Redirect coincident with mem_ack and decode_ready
      ack_delay = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock); #2;
         found = mem_ack;
      end
      check("reach_ack", found, 1'b1);
      redirect    = 1'b1;
      redirect_pc = 16'h0300;
      @(negedge clock); #2;
      redirect = 1'b0;
      cons.delete();
      check("coinc_valid", instruction_valid, 1'b0);
      check("coinc_mem_read", mem_read, 1'b0);
      @(negedge clock); #2;
      check("coinc_new_read", mem_read, 1'b1);
      check("coinc_new_addr", mem_addr, 16'h0300);
      repeat (6) @(negedge clock); #2;
      check("coinc0", got(0), {16'h0300, 16'hA6A5});

      // PC wrap at 16'hFFFF
      pulse_redirect(16'hFFFF);
      repeat (8) @(negedge clock); #2;
      check("wrap0", got(0), {16'hFFFF, 16'h5A5A});
      check("wrap1", got(1), {16'h0000, 16'hA5A5});

      // Reset asserted mid-WAIT with a queued entry
      ack_delay    = 4;
      decode_ready = 1'b0;
      pulse_redirect(16'h0400);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock); #2;
         found = instruction_valid;
      end
      check("mid_queued", found, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock); #2;
         found = mem_read;
      end
      check("mid_wait", found, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_mem_read", mem_read, 1'b0);
      check("mid_rst_mem_addr", mem_addr, 16'h0000);
      check("mid_rst_instr", instruction, 16'h0000);
      check("mid_rst_pc", instruction_pc, 16'h0000);
      check("mid_rst_valid", instruction_valid, 1'b0);
      repeat (2) @(negedge clock); #2;
      ack_delay    = 0;
      decode_ready = 1'b1;
      cons.delete();
      reset_n = 1'b1;
      @(negedge clock); #2;
      check("restart_read", mem_read, 1'b1);
      check("restart_addr", mem_addr, 16'h0010);
      check("restart_bypass_valid", instruction_valid, BYP);
      check("restart_bypass_pc", instruction_pc, BYP ? 16'h0010 : 16'h0000);
      repeat (6) @(negedge clock); #2;
      check("restart0", got(0), {16'h0010, 16'hA5B5});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
